// File: rtl/hangman_core_param.sv
// Hangman game engine: one guess is scanned one letter position per clock,
// then the miss counter, letter history and win/lose outcome are updated.
module hangman_core_param #(
  parameter int WORD_LEN   = 5,
  parameter int MAX_MISSES = 7,
  parameter int MW         = $clog2(MAX_MISSES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  guess_valid,
  input  logic [4:0]            guess_letter,
  input  logic [5*WORD_LEN-1:0] word_in,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [MW-1:0]         miss_count,
  output logic                  win,
  output logic                  lose,
  output logic                  busy,
  output logic                  dup_guess,
  output logic [2:0]            state
);

  localparam int            IW        = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_LEN - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MAX_MISSES);
  localparam logic [4:0]    START_CMD = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_SCAN   = 3'd3,
    S_UPDATE = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [5*WORD_LEN-1:0] word_q, word_d;
  logic [WORD_LEN-1:0]   revealed_q, revealed_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic [25:0]           hist_q, hist_d;
  logic [4:0]            letter_q, letter_d;
  logic                  hit_q, hit_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  dup_q, dup_d;

  logic [31:0]   hist_ext;
  logic          is_start;
  logic          guess_ok;
  logic [4:0]    scan_letter;
  logic          scan_match;
  logic          scan_last;
  logic [MW-1:0] miss_next;

  // Shared decode of the guess, the current scan position and the next miss count
  always_comb begin
    hist_ext    = {6'd0, hist_q};
    is_start    = guess_valid && (guess_letter == START_CMD);
    guess_ok    = (guess_letter < 5'd26) && !hist_ext[guess_letter];
    scan_letter = word_q[5*int'(idx_q) +: 5];
    scan_match  = (scan_letter == letter_q);
    scan_last   = (idx_q == LAST_IDX);
    if (!hit_q && (miss_q != MISS_MAX)) begin
      miss_next = miss_q + MW'(1);
    end else begin
      miss_next = miss_q;
    end
  end

  // State register; reset overrides everything including an in-flight scan
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (is_start) state_d = S_LOAD; else state_d = S_IDLE;
      S_LOAD:   state_d = S_READY;
      S_READY:  if (guess_valid && guess_ok) state_d = S_SCAN; else state_d = S_READY;
      S_SCAN:   if (scan_last) state_d = S_UPDATE; else state_d = S_SCAN;
      S_UPDATE: begin
        // a completed word wins even if this guess also exhausted the misses
        if (&revealed_q)                state_d = S_WIN;
        else if (miss_next == MISS_MAX) state_d = S_LOSE;
        else                            state_d = S_READY;
      end
      S_WIN, S_LOSE: if (guess_valid) state_d = S_IDLE; else state_d = state_q;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values for word, reveal mask, misses, history and scan context
  always_comb begin
    word_d     = word_q;
    revealed_d = revealed_q;
    miss_d     = miss_q;
    hist_d     = hist_q;
    letter_d   = letter_q;
    hit_d      = hit_q;
    idx_d      = idx_q;
    dup_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          word_d     = word_in;
          revealed_d = '0;
          miss_d     = '0;
          hist_d     = 26'd0;
        end else begin
          word_d = word_q;
        end
      end
      S_READY: begin
        if (guess_valid && guess_ok) begin
          letter_d = guess_letter;
          hit_d    = 1'b0;
          idx_d    = '0;
        end else if (guess_valid) begin
          dup_d = 1'b1;
        end else begin
          dup_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (scan_match) begin
          revealed_d = revealed_q | (WORD_LEN'(1) << idx_q);
          hit_d      = 1'b1;
        end else begin
          hit_d = hit_q;
        end
        if (scan_last) idx_d = '0; else idx_d = idx_q + IW'(1);
      end
      S_UPDATE: begin
        hist_d = hist_q | (26'd1 << letter_q);
        miss_d = miss_next;
      end
      S_WIN, S_LOSE: begin
        if (guess_valid) begin
          revealed_d = '0;
          miss_d     = '0;
        end else begin
          revealed_d = revealed_q;
        end
      end
      default: dup_d = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      revealed_q <= '0;
      miss_q     <= '0;
      hist_q     <= 26'd0;
      letter_q   <= 5'd0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      dup_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      revealed_q <= revealed_d;
      miss_q     <= miss_d;
      hist_q     <= hist_d;
      letter_q   <= letter_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      dup_q      <= dup_d;
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    win        = (state_q == S_WIN);
    lose       = (state_q == S_LOSE);
    busy       = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_UPDATE);
    state      = state_q;
    revealed   = revealed_q;
    miss_count = miss_q;
    dup_guess  = dup_q;
  end

endmodule

// File: tb/tb_hangman_core_param.sv
// Scoreboarded bench for hangman_core_param: a reference model predicts each
// guess outcome, plus small WORD_LEN=1/8 instances for the parameter sweep.
module tb_hangman_core_param;
  localparam int WL = 5;
  localparam int MM = 7;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          guess_valid;
  logic [4:0]    guess_letter;
  logic [5*WL-1:0] word_in;
  logic [WL-1:0] revealed;
  logic [MW-1:0] miss_count;
  logic          win, lose, busy, dup_guess;
  logic [2:0]    state;

  logic        s_valid;
  logic [4:0]  s_letter;
  logic [4:0]  s1_word;
  logic [39:0] s8_word;
  logic [0:0]  s1_rev, s1_miss;
  logic [7:0]  s8_rev;
  logic [0:0]  s8_miss;
  logic        s1_win, s1_lose, s1_busy, s1_dup, s8_win, s8_lose, s8_busy, s8_dup;
  logic [2:0]  s1_state, s8_state;

  hangman_core_param #(.WORD_LEN(WL), .MAX_MISSES(MM)) dut (
    .clk(clk), .reset(reset), .guess_valid(guess_valid), .guess_letter(guess_letter),
    .word_in(word_in), .revealed(revealed), .miss_count(miss_count), .win(win),
    .lose(lose), .busy(busy), .dup_guess(dup_guess), .state(state));

  hangman_core_param #(.WORD_LEN(1), .MAX_MISSES(1)) u_s1 (
    .clk(clk), .reset(reset), .guess_valid(s_valid), .guess_letter(s_letter),
    .word_in(s1_word), .revealed(s1_rev), .miss_count(s1_miss), .win(s1_win),
    .lose(s1_lose), .busy(s1_busy), .dup_guess(s1_dup), .state(s1_state));

  hangman_core_param #(.WORD_LEN(8), .MAX_MISSES(1)) u_s8 (
    .clk(clk), .reset(reset), .guess_valid(s_valid), .guess_letter(s_letter),
    .word_in(s8_word), .revealed(s8_rev), .miss_count(s8_miss), .win(s8_win),
    .lose(s8_lose), .busy(s8_busy), .dup_guess(s8_dup), .state(s8_state));

  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0] rev;
    logic [MW-1:0] miss;
    logic [2:0]    st;
    logic          dup;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [25:0] m_hist;
  logic [WL-1:0] m_rev;
  int         m_miss;
  logic [4:0] m_word[WL];

  localparam logic [5*WL-1:0] NOTRE = {5'd4, 5'd17, 5'd19, 5'd14, 5'd13};
  localparam logic [5*WL-1:0] LEVEL = {5'd11, 5'd4, 5'd21, 5'd4, 5'd11};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [5*WL-1:0] w);
    word_in = w;
    guess_valid = 1'b1;
    guess_letter = 5'd31;
    tick();
    guess_valid = 1'b0;
    word_in = '0;
    vectors++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_load: state=%0d busy=%b, expected state=1 busy=1", state, busy);
    end
    tick();
    vectors++;
    if (state !== 3'd2 || revealed !== '0 || miss_count !== '0) begin
      miscompares++;
      $display("FAIL start_ready: state=%0d rev=%b miss=%0d, expected 2/00000/0", state, revealed, miss_count);
    end
    for (int i = 0; i < WL; i++) m_word[i] = w[5*i +: 5];
    m_hist = 26'd0;
    m_rev = '0;
    m_miss = 0;
  endtask

  // Predict the outcome, push it, apply the guess, then pop and compare
  task automatic do_guess(input logic [4:0] l, input bit noisy);
    exp_t e;
    bit   rej;
    bit   hit;
    int   n;
    rej = (l >= 5'd26);
    if (!rej) rej = m_hist[l];
    if (!rej) begin
      m_hist[l] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < WL; i++) if (m_word[i] == l) begin m_rev[i] = 1'b1; hit = 1'b1; end
      if (!hit && m_miss < MM) m_miss++;
    end
    e.rev = m_rev;
    e.miss = MW'(m_miss);
    e.dup = rej;
    e.st = (&m_rev) ? 3'd5 : ((m_miss == MM) ? 3'd6 : 3'd2);
    sb.push_back(e);

    guess_valid = 1'b1;
    guess_letter = l;
    tick();
    guess_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (dup_guess !== e.dup) begin
      miscompares++;
      $display("FAIL dup_pulse letter %0d: dup=%b, expected %b", l, dup_guess, e.dup);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      guess_valid = noisy && (n <= WL);
      guess_letter = 5'd25;
      tick();
      n++;
      if (n == WL) begin
        vectors++;
        if (revealed !== e.rev) begin
          miscompares++;
          $display("FAIL reveal_latency letter %0d: rev=%b at edge k+%0d, expected %b", l, revealed, n, e.rev);
        end
      end
    end
    guess_valid = 1'b0;
    vectors++;
    if (n !== (rej ? 0 : WL + 1)) begin
      miscompares++;
      $display("FAIL guess_latency letter %0d: %0d edges, expected %0d", l, n, rej ? 0 : WL + 1);
    end
    vectors++;
    if (revealed !== e.rev || miss_count !== e.miss || state !== e.st) begin
      miscompares++;
      $display("FAIL guess_result letter %0d: rev=%b miss=%0d state=%0d, expected %b/%0d/%0d",
               l, revealed, miss_count, state, e.rev, e.miss, e.st);
    end
    if (rej) begin
      tick();
      vectors++;
      if (dup_guess !== 1'b0 || state !== 3'd2) begin
        miscompares++;
        $display("FAIL dup_width letter %0d: dup=%b state=%0d, expected 0/2", l, dup_guess, state);
      end
    end
  endtask

  task automatic exit_to_idle;
    guess_valid = 1'b1;
    guess_letter = 5'd0;
    tick();
    guess_valid = 1'b0;
    vectors++;
    if (state !== 3'd0 || revealed !== '0 || miss_count !== '0 || win !== 1'b0 || lose !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_idle: state=%0d rev=%b miss=%0d win=%b lose=%b, expected all 0",
               state, revealed, miss_count, win, lose);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    guess_valid = 1'b1;
    guess_letter = 5'd31;
    word_in = NOTRE;
    s_valid = 1'b0;
    s_letter = 5'd0;
    s1_word = 5'd2;
    s8_word = {8{5'd2}};
    tick();
    tick();
    vectors++;
    if (state !== 3'd0 || revealed !== '0 || miss_count !== '0 || win || lose || busy || dup_guess) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d rev=%b miss=%0d flags=%b%b%b%b, expected all 0",
               state, revealed, miss_count, win, lose, busy, dup_guess);
    end
    reset = 1'b0;
    guess_letter = 5'd3;
    tick();
    guess_valid = 1'b0;
    vectors++;
    if (state !== 3'd0) begin
      miscompares++;
      $display("FAIL idle_ignore: state=%0d, expected 0", state);
    end
  endtask

  task automatic test_win_notre;
    logic [4:0] g[WL] = '{5'd13, 5'd14, 5'd19, 5'd17, 5'd4};
    start_game(NOTRE);
    foreach (g[i]) do_guess(g[i], 1'b0);
    vectors++;
    if (win !== 1'b1 || revealed !== 5'b11111 || miss_count !== 3'd0) begin
      miscompares++;
      $display("FAIL notre_win: win=%b rev=%b miss=%0d, expected 1/11111/0", win, revealed, miss_count);
    end
    exit_to_idle();
  endtask

  task automatic test_level;
    start_game(LEVEL);
    do_guess(5'd11, 1'b1);
    do_guess(5'd4, 1'b1);
    vectors++;
    if (revealed !== 5'b11011 || miss_count !== 3'd0) begin
      miscompares++;
      $display("FAIL level_multi: rev=%b miss=%0d, expected 11011/0", revealed, miss_count);
    end
  endtask

  task automatic test_lose;
    logic [4:0] g[7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7};
    start_game(NOTRE);
    foreach (g[i]) do_guess(g[i], 1'b0);
    vectors++;
    if (lose !== 1'b1 || miss_count !== 3'd7) begin
      miscompares++;
      $display("FAIL notre_lose: lose=%b miss=%0d, expected 1/7", lose, miss_count);
    end
    exit_to_idle();
  endtask

  task automatic test_dup;
    start_game(NOTRE);
    do_guess(5'd14, 1'b0);
    do_guess(5'd14, 1'b0);
    do_guess(5'd27, 1'b0);
    exit_to_idle_from_ready();
  endtask

  task automatic exit_to_idle_from_ready;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    start_game(NOTRE);
    guess_valid = 1'b1;
    guess_letter = 5'd13;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (state !== 3'd3 || revealed !== 5'b00001) begin
      miscompares++;
      $display("FAIL scan_partial: state=%0d rev=%b, expected 3/00001", state, revealed);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (state !== 3'd0 || revealed !== '0 || miss_count !== '0 || win || lose || busy || dup_guess) begin
      miscompares++;
      $display("FAIL reset_mid_scan: state=%0d rev=%b miss=%0d, expected all 0", state, revealed, miss_count);
    end
    start_game(NOTRE);
    do_guess(5'd13, 1'b0);
    do_guess(5'd0, 1'b0);
  endtask

  task automatic sweep_guess(input logic [4:0] l, input logic exp_win);
    int n1, n8;
    s_valid = 1'b1;
    s_letter = l;
    tick();
    s_valid = 1'b0;
    n1 = -1;
    n8 = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!s1_busy && n1 < 0) n1 = n;
      if (!s8_busy && n8 < 0) n8 = n;
    end
    vectors++;
    if (n1 !== 2 || n8 !== 9) begin
      miscompares++;
      $display("FAIL sweep_latency: w1=%0d w8=%0d, expected 2/9", n1, n8);
    end
    vectors++;
    if (s1_win !== exp_win || s1_lose !== !exp_win || s8_win !== exp_win || s8_lose !== !exp_win ||
        s1_miss !== 1'(!exp_win) || s8_miss !== 1'(!exp_win) ||
        s1_rev !== {1{exp_win}} || s8_rev !== {8{exp_win}}) begin
      miscompares++;
      $display("FAIL sweep_outcome: w1 win/lose/miss=%b%b%b w8=%b%b%b rev=%b/%b, expected win=%b",
               s1_win, s1_lose, s1_miss, s8_win, s8_lose, s8_miss, s1_rev, s8_rev, exp_win);
    end
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_param_sweep;
    for (int r = 0; r < 2; r++) begin
      s_valid = 1'b1;
      s_letter = 5'd31;
      tick();
      s_valid = 1'b0;
      tick();
      vectors++;
      if (s1_state !== 3'd2 || s8_state !== 3'd2) begin
        miscompares++;
        $display("FAIL sweep_start: states %0d/%0d, expected 2/2", s1_state, s8_state);
      end
      sweep_guess(r == 0 ? 5'd25 : 5'd2, r == 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    guess_valid = 1'b0;
    guess_letter = 5'd0;
    word_in = '0;
    test_reset();
    test_win_notre();
    test_level();
    exit_to_idle_from_ready();
    test_lose();
    test_dup();
    test_reset_mid_scan();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hangman_core_param.md
HANGMAN_CORE_PARAM -- requirements
Module: hangman_core_param

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5: number of letters per word (legal 1..16).
REQ-002 SHALL have parameter MAX_MISSES, default 7: wrong guesses allowed before loss (legal 1..15).
REQ-003 SHALL have parameter MW = $clog2(MAX_MISSES+1), derived: miss counter width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port guess_valid, input, 1: guess/command strobe, sampled each edge.
REQ-007 SHALL have port guess_letter, input, 5: letter code, a=0 .. z=25; 31 = start command.
REQ-008 SHALL have port word_in, input, 5*WORD_LEN: secret word; position i at bits [5i+4:5i].
REQ-009 SHALL have port revealed, output, WORD_LEN: bit i set when position i has been guessed.
REQ-010 SHALL have port miss_count, output, MW: wrong guesses so far.
REQ-011 SHALL have ports win and lose, output, 1 each: level outputs, high while in WIN or LOSE.
REQ-012 SHALL have port busy, output, 1: high in LOAD, SCAN and UPDATE.
REQ-013 SHALL have port dup_guess, output, 1: one-cycle pulse on a repeated or invalid letter.
REQ-014 SHALL have port state, output, 3: debug state code, IDLE=0, LOAD=1, READY=2, SCAN=3, UPDATE=4, WIN=5, LOSE=6.

Function
REQ-015 IDLE SHALL move to LOAD on guess_valid with guess_letter=31; all other input in IDLE is ignored.
REQ-016 On entering LOAD the block SHALL latch word_in and clear revealed, miss_count and the 26-bit guessed-letter history; LOAD SHALL go to READY on the next edge.
REQ-017 In READY, guess_valid with a letter 0..25 that is not in the history SHALL latch the letter, clear the hit flag, set the scan index to 0 and move to SCAN.
REQ-018 In READY, guess_valid with a letter already in the history, or a code 26..31, SHALL pulse dup_guess for one cycle, stay in READY, and leave all counters unchanged.
REQ-019 SCAN SHALL compare one position per cycle, index 0 to WORD_LEN-1.
REQ-020 During SCAN, each matching position SHALL set its revealed bit and the hit flag, so every occurrence of the letter is revealed.
REQ-021 SCAN SHALL go to UPDATE after index WORD_LEN-1.
REQ-022 UPDATE SHALL set the letter's history bit and, if hit=0, increment miss_count; it saturates at MAX_MISSES.
REQ-023 UPDATE SHALL then go to WIN if all revealed bits are 1, else to LOSE if the new miss_count = MAX_MISSES, else to READY; a win takes priority over a loss.
REQ-024 Latency: a guess accepted at edge k SHALL leave revealed final at edge k+WORD_LEN, and miss_count and the next state at edge k+WORD_LEN+1.
REQ-025 guess_valid during LOAD, SCAN or UPDATE SHALL be ignored, not queued.
REQ-026 In WIN or LOSE, any guess_valid SHALL go to IDLE, clearing revealed and miss_count on that edge; win/lose deassert on that edge.
REQ-027 dup_guess SHALL be 0 in every cycle other than the one following a rejected guess.

Reset
REQ-028 reset SHALL put the block in IDLE on the next edge and force revealed=0, miss_count=0, win=0, lose=0, busy=0, dup_guess=0, history=0 and the latched word=0.
REQ-029 reset SHALL take priority over all other inputs, including in the middle of SCAN; no partial reveal or miss survives it.

Verification
REQ-030 WORD_LEN=5, word "notre" (13,14,19,17,4): start with 31, then guess n,o,t,r,e -> revealed 00001, 00011, 00111, 01111, 11111; win=1, miss_count=0; each guess READY again 6 edges after acceptance.
REQ-031 Word "level" (11,4,21,4,11): guess l -> revealed=10001; guess e -> revealed=11011; miss_count stays 0.
REQ-032 Word "notre": guess a seven times with distinct misses a,b,c,d,f,g,h -> miss_count 1..7, lose=1 after the 7th; then guess_valid -> IDLE, miss_count=0.
REQ-033 Guess o twice, then letter 27 -> second o and 27 each give a one-cycle dup_guess pulse; miss_count and revealed unchanged; state stays READY.
REQ-034 Assert reset during SCAN at index 2 -> state=0 and all outputs 0 next cycle; start command then works normally.
REQ-035 Parameter sweep WORD_LEN=1 and 8, MAX_MISSES=1: one miss -> lose; full word -> win; latency = WORD_LEN+1 edges.
